// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and key-code helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Key code is 4*row + col, which is simply the concatenation of the two indices.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // One-cold row drive: the selected row is pulled low.
  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  // Lowest-index low column; only meaningful when at least one column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    if (!cols[0])      return 2'd0;
    else if (!cols[1]) return 2'd1;
    else if (!cols[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad columns; resets to the idle (pulled-up) level.
module sync_2ff #(
  parameter int          WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobing, column debounce and single-key press/release tracking.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keypad_value,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam logic [15:0] DWELL_MAX  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_TARGET = 8'(DEBOUNCE_COUNT);

  logic [3:0]  col_sync;
  kp_state_t   state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  cand_q, cand_d;
  logic [7:0]  deb_q, deb_d;
  logic [15:0] dwell_q;
  logic [3:0]  value_d;
  logic        valid_d;
  logic        pressed_d;
  logic        sample;
  logic        cand_low;
  logic [7:0]  deb_inc;
  logic [1:0]  first_low;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_in),
    .q     (col_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
    end else if (dwell_q == DWELL_MAX) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + 16'd1;
    end
  end

  assign sample    = (dwell_q == DWELL_MAX);
  assign cand_low  = ~col_sync[cand_q];
  assign deb_inc   = deb_q + 8'd1;
  assign first_low = lowest_low(col_sync);

  // Columns are only examined at the end of each dwell period; between samples nothing moves.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    value_d   = keypad_value;
    valid_d   = key_valid;
    pressed_d = 1'b0;
    if (sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (col_sync != 4'b1111) begin
            cand_d = first_low;
            if (DEB_TARGET == 8'd1) begin
              value_d   = key_code(row_q, first_low);
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              deb_d     = '0;
              state_d   = ST_HELD;
            end else begin
              deb_d   = 8'd1;
              state_d = ST_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (cand_low) begin
            if (deb_inc == DEB_TARGET) begin
              value_d   = key_code(row_q, cand_q);
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              deb_d     = '0;
              state_d   = ST_HELD;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!cand_low) begin
            if (DEB_TARGET == 8'd1) begin
              valid_d = 1'b0;
              deb_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              deb_d   = 8'd1;
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (!cand_low) begin
            if (deb_inc == DEB_TARGET) begin
              valid_d = 1'b0;
              deb_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d   = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // row_out is registered from the next row index, so it follows row_q on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SCAN;
      row_q        <= 2'd0;
      cand_q       <= 2'd0;
      deb_q        <= '0;
      row_out      <= 4'b1110;
      keypad_value <= 4'd0;
      key_valid    <= 1'b0;
      key_pressed  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cand_q       <= cand_d;
      deb_q        <= deb_d;
      row_out      <= row_drive(row_d);
      keypad_value <= value_d;
      key_valid    <= valid_d;
      key_pressed  <= pressed_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_COUNT=3 and a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  keypad_value;
  logic        key_valid;
  logic        key_pressed;

  logic [15:0] keys = '0;
  int          tests = 0;
  int          fails = 0;
  int          sample_cnt = 0;
  int          pulse_cnt = 0;
  int          valid_low_cnt = 0;
  logic [1:0]  tb_dwell = '0;

  typedef struct {
    logic [1:0] row;
    logic [3:0] cols;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[6];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_COUNT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .col_in       (col_in),
    .row_out      (row_out),
    .keypad_value (keypad_value),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
  end

  // Reference dwell phase: a sample point ends every fourth cycle out of reset.
  always @(posedge clk) begin
    if (reset) begin
      tb_dwell <= '0;
    end else if (tb_dwell == 2'd3) begin
      tb_dwell   <= '0;
      sample_cnt <= sample_cnt + 1;
    end else begin
      tb_dwell <= tb_dwell + 2'd1;
    end
  end

  always @(negedge clk) begin
    if (key_pressed) pulse_cnt <= pulse_cnt + 1;
    if (!key_valid)  valid_low_cnt <= valid_low_cnt + 1;
  end

  // ---- driver / checker tasks ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_samples(input int n);
    int target;
    target = sample_cnt + n;
    while (sample_cnt < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_row_out", row_out, 4'b1110);
    check("reset_value", keypad_value, 4'd0);
    check("reset_valid", key_valid, 1'b0);
    check("reset_pressed", key_pressed, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] exp_row(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (r % 4));
  endfunction

  // ---- scoreboard / stimulus ----
  initial begin
    int   p0;
    int   v0;
    bit   found;
    vecs[0] = '{row: 2'd2, cols: 4'b0010, code: 4'd9};
    vecs[1] = '{row: 2'd1, cols: 4'b0101, code: 4'd4};
    vecs[2] = '{row: 2'd0, cols: 4'b1000, code: 4'd3};
    vecs[3] = '{row: 2'd3, cols: 4'b1000, code: 4'd15};
    vecs[4] = '{row: 2'd0, cols: 4'b0001, code: 4'd0};
    vecs[5] = '{row: 2'd3, cols: 4'b1100, code: 4'd14};

    // Idle scan: each row driven for four cycles in order 0..3.
    do_reset();
    for (int j = 0; j <= 16; j++) begin
      check("idle_row_out", row_out, exp_row(j / 4));
      check("idle_no_pulse", key_pressed, 1'b0);
      @(negedge clk);
    end

    // Row 0 col 3 seen for two samples then bounces away: no acceptance.
    do_reset();
    p0 = pulse_cnt;
    keys[3] = 1'b1;
    wait_samples(2);
    check("bounce_valid", key_valid, 1'b0);
    keys = '0;
    wait_samples(1);
    check("bounce_row_resume", row_out, 4'b1101);
    check("bounce_value", keypad_value, 4'd0);
    wait_samples(1);
    check("bounce_row_next", row_out, 4'b1011);
    wait_samples(4);
    check("bounce_pulses", pulse_cnt - p0, 0);

    // Key 9 from reset: reached at sample 3, accepted at sample 5.
    do_reset();
    keys[9] = 1'b1;
    wait_samples(4);
    check("k9_not_yet", key_valid, 1'b0);
    check("k9_no_pulse_yet", key_pressed, 1'b0);
    wait_samples(1);
    check("k9_pressed", key_pressed, 1'b1);
    check("k9_value", keypad_value, 4'd9);
    check("k9_valid", key_valid, 1'b1);
    keys = '0;
    wait_samples(2);
    check("k9_release_pending", key_valid, 1'b1);
    wait_samples(1);
    check("k9_released", key_valid, 1'b0);
    check("k9_row_after", row_out, 4'b0111);

    // Table: press, accept, hold, release for each key pattern.
    for (int i = 0; i < 6; i++) begin
      p0 = pulse_cnt;
      keys = '0;
      for (int c = 0; c < 4; c++)
        if (vecs[i].cols[c]) keys[4*int'(vecs[i].row)+c] = 1'b1;
      found = 1'b0;
      for (int s = 0; s < 24 && !found; s++) begin
        wait_samples(1);
        if (key_pressed) found = 1'b1;
      end
      check("tbl_accept_seen", found, 1'b1);
      check("tbl_value", keypad_value, vecs[i].code);
      check("tbl_valid", key_valid, 1'b1);
      @(negedge clk);
      check("tbl_pulse_width", key_pressed, 1'b0);
      wait_samples(2);
      check("tbl_held_valid", key_valid, 1'b1);
      keys = '0;
      wait_samples(2);
      check("tbl_release_pending", key_valid, 1'b1);
      wait_samples(1);
      check("tbl_released", key_valid, 1'b0);
      check("tbl_row_after", row_out, exp_row(int'(vecs[i].row) + 1));
      check("tbl_pulse_count", pulse_cnt - p0, 1);
      check("tbl_value_held", keypad_value, vecs[i].code);
    end

    // Key 5 released for two samples then pressed again: stays valid, no second pulse.
    do_reset();
    keys[5] = 1'b1;
    wait_samples(4);
    check("k5_pressed", key_pressed, 1'b1);
    check("k5_value", keypad_value, 4'd5);
    @(negedge clk);
    p0 = pulse_cnt;
    v0 = valid_low_cnt;
    keys = '0;
    wait_samples(2);
    keys[5] = 1'b1;
    wait_samples(1);
    wait_samples(3);
    check("k5_glitch_valid", key_valid, 1'b1);
    check("k5_valid_never_low", valid_low_cnt - v0, 0);
    check("k5_no_second_pulse", pulse_cnt - p0, 0);
    check("k5_value_kept", keypad_value, 4'd5);
    keys = '0;
    wait_samples(3);
    check("k5_released", key_valid, 1'b0);
    check("k5_row_after", row_out, 4'b1011);

    // Key 2 in debounce when reset hits; re-accepted three samples after reset.
    p0 = pulse_cnt;
    keys[2] = 1'b1;
    wait_samples(4);
    check("rst_mid_valid", key_valid, 1'b0);
    check("rst_mid_value", keypad_value, 4'd5);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_row_out", row_out, 4'b1110);
    check("rst_mid_value0", keypad_value, 4'd0);
    check("rst_mid_valid0", key_valid, 1'b0);
    check("rst_mid_pressed0", key_pressed, 1'b0);
    reset = 1'b0;
    wait_samples(2);
    check("rst_mid_no_pulse", pulse_cnt - p0, 0);
    check("rst_reaccept_wait", key_valid, 1'b0);
    wait_samples(1);
    check("rst_reaccept_pressed", key_pressed, 1'b1);
    check("rst_reaccept_value", keypad_value, 4'd2);
    check("rst_reaccept_valid", key_valid, 1'b1);
    keys = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, 1000, clock cycles each row is driven before its columns are sampled (dwell period); legal range 4..65535.
REQ-002 DEBOUNCE_COUNT, 8, consecutive identical dwell samples needed to accept a press or a release; legal range 1..255.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 col_in  in  4  raw keypad columns; asynchronous, active-low, pulled up.
REQ-006 row_out  out  4  keypad row drive; one-cold, so the driven row is low.
REQ-007 keypad_value  out  4  code of the last accepted key; held after release.
REQ-008 key_valid  out  1  high while the accepted key is held.
REQ-009 key_pressed  out  1  one-cycle pulse when a press is accepted.

Function
REQ-010 col_in SHALL pass through a two-flop synchronizer before use; all column references below mean the synchronized value.
REQ-011 Key code SHALL be 4*row + col, with row and col in 0..3.
REQ-012 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; the sample point is the cycle where the count equals SCAN_DIV-1.
REQ-013 The FSM SHALL have four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: at each sample point with all columns high, the row index SHALL advance (3 wraps to 0) and row_out SHALL update on the next cycle.
REQ-015 SCAN: at a sample point with any column low:
- capture the candidate column (lowest index wins if several are low)
- set the debounce count to 1
- enter DEBOUNCE; the row index does not advance
REQ-016 DEBOUNCE: at each sample point, if the candidate column is low, the count SHALL increment.
REQ-017 DEBOUNCE: if the candidate column is high at a sample point, the FSM SHALL clear the count, advance the row, and return to SCAN.
REQ-018 When the count reaches DEBOUNCE_COUNT, on that sample cycle's next edge the block SHALL:
- load keypad_value with the candidate code
- assert key_valid
- pulse key_pressed for exactly one cycle
- enter HELD
REQ-019 With DEBOUNCE_COUNT=1, acceptance SHALL occur directly from SCAN at the first low sample.
REQ-020 HELD: the row stays fixed; a sample with the candidate column high SHALL set the count to 1 and enter RELEASE.
REQ-021 RELEASE: each high sample SHALL increment the count; at DEBOUNCE_COUNT the FSM SHALL deassert key_valid, advance the row and enter SCAN.
REQ-022 RELEASE: a low sample SHALL return the FSM to HELD with no key_pressed pulse; key_valid stays high.
REQ-023 Other keys pressed while in DEBOUNCE, HELD or RELEASE SHALL be ignored; there is no multi-key rollover.
REQ-024 keypad_value SHALL change only at acceptance.
REQ-025 Debounce counter width SHALL be 8 bits; the dwell counter SHALL be 16 bits.

Reset
REQ-026 Reset SHALL set:
- row_out to 4'b1110 and row index to 0
- the FSM to SCAN
- dwell and debounce counters to 0
- keypad_value to 0, key_valid to 0, key_pressed to 0
- synchronizer flops to 4'b1111
REQ-027 Reset asserted mid-press SHALL abort without a key_pressed pulse.
REQ-028 A key still held after reset SHALL be re-accepted through the normal debounce.

Structure
REQ-029 The state encoding and the key-code formula SHALL live in a shared package, keypad_pkg.
REQ-030 The synchronizer SHALL be a sub-module, sync_2ff, four bits wide, instantiated once.
REQ-031 All outputs SHALL be registered.

Verification (SCAN_DIV=4, DEBOUNCE_COUNT=3)
REQ-032 Idle after reset -> row_out cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_pressed never asserts.
REQ-033 Row 2, col 1 held clean -> one key_pressed pulse; keypad_value=9; key_valid high until release is confirmed 3 samples after release.
REQ-034 Press row 0, col 3 for 2 samples then bounce high -> no pulse; keypad_value stays 0; scanning resumes.
REQ-035 Held key 5 released for 2 samples then low again -> key_valid never drops; no second pulse.
REQ-036 Row 1, col 0 and col 2 low together -> keypad_value=4.
REQ-037 Reset asserted in DEBOUNCE -> outputs match REQ-026 on the next cycle; the key is re-accepted 3 samples after reset releases.
